// File: rtl/rmii_rx_framer_if.sv
// RMII receive pins plus framed byte stream and per-frame status.
// master: framer side (pins in, stream/status out); slave: PHY/consumer side.
interface rmii_rx_framer_if;
  logic [1:0]  rmii_rxd;
  logic        rmii_crs_dv;
  logic        rmii_rx_er;
  logic [7:0]  received_byte;
  logic        byte_valid;
  logic        frame_active;
  logic        frame_done;
  logic        frame_good;
  logic [15:0] frame_len;
  logic        err_crc;
  logic        err_align;
  logic        err_rx;
  logic        err_len;

  modport master (
    input  rmii_rxd, rmii_crs_dv, rmii_rx_er,
    output received_byte, byte_valid, frame_active,
    output frame_done, frame_good, frame_len,
    output err_crc, err_align, err_rx, err_len
  );

  modport slave (
    output rmii_rxd, rmii_crs_dv, rmii_rx_er,
    input  received_byte, byte_valid, frame_active,
    input  frame_done, frame_good, frame_len,
    input  err_crc, err_align, err_rx, err_len
  );
endinterface

// File: rtl/rmii_rx_framer.sv
// RMII receive framer: SFD hunt, LSB-first byte assembly, CRC/len/align/rx_er status.
// Ports: clk, reset (async, active-high), bus (rmii_rx_framer_if.master).
module rmii_rx_framer #(
  parameter int MAX_FRAME_BYTES = 1522,
  parameter int MIN_FRAME_BYTES = 64,
  parameter int HUNT_LIMIT      = 64
) (
  input  logic             clk,
  input  logic             reset,
  rmii_rx_framer_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HUNT,
    S_DATA,
    S_DROP
  } state_t;

  localparam int          HW        = $clog2(HUNT_LIMIT + 1);
  localparam logic [HW-1:0] HUNT_LAST = HW'(HUNT_LIMIT - 1);
  localparam logic [15:0] MAX_L     = 16'(MAX_FRAME_BYTES);
  localparam logic [15:0] MIN_L     = 16'(MIN_FRAME_BYTES);
  localparam logic [31:0] POLY      = 32'hEDB88320;
  localparam logic [31:0] RESIDUE   = 32'hDEBB20E3;

  state_t        state;
  logic [1:0]    rxd_d1;
  logic          crs_dv_d1;
  logic          rx_er_d1;
  logic [7:0]    window;
  logic [HW-1:0] hunt_cnt;
  logic [5:0]    sr;
  logic [1:0]    dibit_cnt;
  logic [15:0]   cnt;
  logic [31:0]   crc;
  logic          f_rx;
  logic          f_len;
  logic          from_data;

  logic [7:0]    rx_byte_q;
  logic          byte_valid_q;
  logic          active_q;
  logic          done_q;
  logic          good_q;
  logic [15:0]   len_q;
  logic          crc_q;
  logic          align_q;
  logic          rx_q;
  logic          len_err_q;

  logic          eoc;
  logic          fin;
  logic [7:0]    win_nxt;
  logic [7:0]    byte_nxt;
  logic [15:0]   cnt_inc;
  logic          st_align;
  logic          st_rx;
  logic          st_len;
  logic          st_crc;

  function automatic logic [31:0] crc_byte(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ POLY;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // Carrier ends only when CRS_DV is low on two samples in a row;
  // a single low sample is the RMII end-of-carrier toggle.
  assign eoc      = !crs_dv_d1 && !bus.rmii_crs_dv;
  assign win_nxt  = {rxd_d1, window[7:2]};
  assign byte_nxt = {rxd_d1, sr};
  assign cnt_inc  = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  assign fin      = eoc && ((state == S_DATA) ||
                            (state == S_DROP && from_data));
  assign st_align = (dibit_cnt != 2'd0);
  assign st_rx    = f_rx || rx_er_d1;
  assign st_len   = f_len || (cnt < MIN_L);
  assign st_crc   = (cnt < 16'd4) || (crc != RESIDUE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_DROP;
      rxd_d1       <= '0;
      crs_dv_d1    <= 1'b0;
      rx_er_d1     <= 1'b0;
      window       <= '0;
      hunt_cnt     <= '0;
      sr           <= '0;
      dibit_cnt    <= '0;
      cnt          <= '0;
      crc          <= 32'hFFFFFFFF;
      f_rx         <= 1'b0;
      f_len        <= 1'b0;
      from_data    <= 1'b0;
      rx_byte_q    <= '0;
      byte_valid_q <= 1'b0;
      active_q     <= 1'b0;
      done_q       <= 1'b0;
      good_q       <= 1'b0;
      len_q        <= '0;
      crc_q        <= 1'b0;
      align_q      <= 1'b0;
      rx_q         <= 1'b0;
      len_err_q    <= 1'b0;
    end else begin
      rxd_d1       <= bus.rmii_rxd;
      crs_dv_d1    <= bus.rmii_crs_dv;
      rx_er_d1     <= bus.rmii_rx_er;
      byte_valid_q <= 1'b0;
      done_q       <= fin;

      if (fin) begin
        len_q     <= cnt;
        align_q   <= st_align;
        rx_q      <= st_rx;
        len_err_q <= st_len;
        crc_q     <= st_crc;
        good_q    <= !(st_align || st_rx || st_len || st_crc);
      end

      case (state)
        S_IDLE: begin
          window   <= '0;
          hunt_cnt <= '0;
          if (crs_dv_d1) state <= S_HUNT;
        end

        // In HUNT a non-ended cycle always carries a valid dibit.
        S_HUNT: begin
          if (eoc) begin
            state <= S_IDLE;
          end else if (win_nxt == 8'hD5) begin
            rx_byte_q    <= 8'hD5;
            byte_valid_q <= 1'b1;
            active_q     <= 1'b1;
            dibit_cnt    <= '0;
            cnt          <= '0;
            crc          <= 32'hFFFFFFFF;
            f_rx         <= 1'b0;
            f_len        <= 1'b0;
            from_data    <= 1'b0;
            good_q       <= 1'b0;
            len_q        <= '0;
            crc_q        <= 1'b0;
            align_q      <= 1'b0;
            rx_q         <= 1'b0;
            len_err_q    <= 1'b0;
            state        <= S_DATA;
          end else begin
            window <= win_nxt;
            if (hunt_cnt == HUNT_LAST) state <= S_DROP;
            else hunt_cnt <= hunt_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (eoc) begin
            active_q <= 1'b0;
            state    <= S_IDLE;
          end else if (rx_er_d1) begin
            f_rx      <= 1'b1;
            from_data <= 1'b1;
            active_q  <= 1'b0;
            state     <= S_DROP;
          end else begin
            dibit_cnt <= dibit_cnt + 2'd1;
            unique case (dibit_cnt)
              2'd0: sr[1:0] <= rxd_d1;
              2'd1: sr[3:2] <= rxd_d1;
              2'd2: sr[5:4] <= rxd_d1;
              2'd3: begin
                rx_byte_q    <= byte_nxt;
                byte_valid_q <= 1'b1;
                cnt          <= cnt_inc;
                crc          <= crc_byte(crc, byte_nxt);
                if (cnt_inc > MAX_L) begin
                  f_len     <= 1'b1;
                  from_data <= 1'b1;
                  active_q  <= 1'b0;
                  state     <= S_DROP;
                end
              end
            endcase
          end
        end

        S_DROP: begin
          if (eoc) begin
            from_data <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: state <= S_DROP;
      endcase
    end
  end

  assign bus.received_byte = rx_byte_q;
  assign bus.byte_valid    = byte_valid_q;
  assign bus.frame_active  = active_q;
  assign bus.frame_done    = done_q;
  assign bus.frame_good    = good_q;
  assign bus.frame_len     = len_q;
  assign bus.err_crc       = crc_q;
  assign bus.err_align     = align_q;
  assign bus.err_rx        = rx_q;
  assign bus.err_len       = len_err_q;

endmodule

// File: tb/tb_rmii_rx_framer.sv
// Directed bench for rmii_rx_framer: good/bad CRC, CRS_DV toggle, rx_er,
// alignment, short frame, hunt limit and mid-frame reset.
module tb_rmii_rx_framer;

  logic clk = 1'b0;
  logic reset;
  always #10 clk = ~clk;

  rmii_rx_framer_if bus ();

  rmii_rx_framer #(
    .MAX_FRAME_BYTES(1522),
    .MIN_FRAME_BYTES(64),
    .HUNT_LIMIT     (64)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0]  frm[$];
  logic [7:0]  rx_q[$];
  int          done_cnt = 0;
  logic        s_good, s_crc, s_align, s_rx, s_lenerr;
  logic [15:0] s_len;

  always @(negedge clk) begin
    if (bus.byte_valid) rx_q.push_back(bus.received_byte);
    if (bus.frame_done) begin
      done_cnt <= done_cnt + 1;
      s_good   <= bus.frame_good;
      s_len    <= bus.frame_len;
      s_crc    <= bus.err_crc;
      s_align  <= bus.err_align;
      s_rx     <= bus.err_rx;
      s_lenerr <= bus.err_len;
    end
  end

  task automatic drive_dibit(input logic [1:0] d, input logic dv,
                             input logic er);
    @(negedge clk);
    bus.rmii_rxd    = d;
    bus.rmii_crs_dv = dv;
    bus.rmii_rx_er  = er;
  endtask

  task automatic drive_byte(input logic [7:0] b);
    for (int k = 0; k < 4; k++) drive_dibit(b[2*k +: 2], 1'b1, 1'b0);
  endtask

  task automatic preamble();
    repeat (7) drive_byte(8'h55);
    drive_byte(8'hD5);
  endtask

  task automatic carrier_off();
    drive_dibit(2'b00, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
  endtask

  // Payload 0,1,2,... followed by FCS (~CRC, low byte first).
  task automatic build_frame(input int npay);
    logic [31:0] c;
    logic [7:0]  b;
    logic        fb;
    frm.delete();
    for (int i = 0; i < npay; i++) frm.push_back(8'(i));
    c = 32'hFFFFFFFF;
    for (int i = 0; i < npay; i++) begin
      b = frm[i];
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ b[j];
        c  = {1'b0, c[31:1]};
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    c = ~c;
    frm.push_back(c[7:0]);
    frm.push_back(c[15:8]);
    frm.push_back(c[23:16]);
    frm.push_back(c[31:24]);
  endtask

  // extra: trailing dibits; toggle: CRS_DV 0,1,.. over last 8 dibits;
  // er_byte: rx_er on dibit 0 of that frame byte (-1 = none).
  task automatic send_frame(input int extra, input bit toggle,
                            input int er_byte);
    int         n;
    int         nd;
    logic [7:0] b;
    logic [1:0] d;
    logic       dv;
    logic       er;
    preamble();
    nd = frm.size() * 4;
    n  = nd + extra;
    for (int j = 0; j < n; j++) begin
      if (j < nd) begin
        b = frm[j/4];
        d = b[2*(j%4) +: 2];
      end else begin
        d = 2'b10;
      end
      dv = !(toggle && j >= n - 8 && ((j - (n - 8)) % 2 == 0));
      er = (er_byte >= 0) && (j == er_byte * 4);
      drive_dibit(d, dv, er);
    end
    carrier_off();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.rmii_rxd    = 2'b00;
    bus.rmii_crs_dv = 1'b0;
    bus.rmii_rx_er  = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.received_byte, bus.byte_valid, bus.frame_active,
         bus.frame_done, bus.frame_good, bus.frame_len, bus.err_crc,
         bus.err_align, bus.err_rx, bus.err_len} !== 33'd0) begin
      failures++;
      $display("FAIL reset_outputs: nonzero output during reset");
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (done_cnt !== 0 || bus.frame_active !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: done=%0d active=%b required 0/0",
               done_cnt, bus.frame_active);
    end
  endtask

  task automatic test_good_frame();
    int q0, d0, got;
    q0 = rx_q.size();
    d0 = done_cnt;
    build_frame(60);
    send_frame(0, 1'b0, -1);
    got = rx_q.size() - q0;
    checks++;
    if (got !== 65) begin
      failures++;
      $display("FAIL good_count: got %0d required 65", got);
    end
    for (int i = 0; i < got && i < 65; i++) begin
      checks++;
      if (rx_q[q0+i] !== ((i == 0) ? 8'hD5 : frm[i-1])) begin
        failures++;
        $display("FAIL good_byte[%0d]: got %h required %h", i, rx_q[q0+i],
                 (i == 0) ? 8'hD5 : frm[i-1]);
      end
    end
    checks++;
    if (done_cnt - d0 !== 1 || s_good !== 1'b1 || s_len !== 16'd64) begin
      failures++;
      $display("FAIL good_status: done=%0d good=%b len=%0d required 1/1/64",
               done_cnt - d0, s_good, s_len);
    end
    checks++;
    if ({s_crc, s_align, s_rx, s_lenerr} !== 4'b0000) begin
      failures++;
      $display("FAIL good_errs: got %b required 0000",
               {s_crc, s_align, s_rx, s_lenerr});
    end
    checks++;
    if (bus.frame_active !== 1'b0) begin
      failures++;
      $display("FAIL good_inactive: active=%b required 0", bus.frame_active);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (bus.frame_good !== 1'b1 || bus.frame_len !== 16'd64) begin
      failures++;
      $display("FAIL status_hold: good=%b len=%0d required 1/64",
               bus.frame_good, bus.frame_len);
    end
  endtask

  task automatic test_crc_error();
    int q0, d0, got;
    q0 = rx_q.size();
    d0 = done_cnt;
    build_frame(60);
    frm[10] = frm[10] ^ 8'h01;
    send_frame(0, 1'b0, -1);
    got = rx_q.size() - q0;
    checks++;
    if (got !== 65) begin
      failures++;
      $display("FAIL crc_count: got %0d required 65", got);
    end
    for (int i = 1; i < got && i < 65; i++) begin
      checks++;
      if (rx_q[q0+i] !== frm[i-1]) begin
        failures++;
        $display("FAIL crc_byte[%0d]: got %h required %h", i, rx_q[q0+i],
                 frm[i-1]);
      end
    end
    checks++;
    if (done_cnt - d0 !== 1 || s_crc !== 1'b1 || s_good !== 1'b0 ||
        s_len !== 16'd64) begin
      failures++;
      $display("FAIL crc_status: done=%0d crc=%b good=%b len=%0d required 1/1/0/64",
               done_cnt - d0, s_crc, s_good, s_len);
    end
  endtask

  task automatic test_crs_toggle();
    int q0, d0;
    q0 = rx_q.size();
    d0 = done_cnt;
    build_frame(60);
    send_frame(0, 1'b1, -1);
    checks++;
    if (rx_q.size() - q0 !== 65 || done_cnt - d0 !== 1) begin
      failures++;
      $display("FAIL toggle_count: bytes=%0d done=%0d required 65/1",
               rx_q.size() - q0, done_cnt - d0);
    end
    checks++;
    if (s_good !== 1'b1 || s_len !== 16'd64) begin
      failures++;
      $display("FAIL toggle_status: good=%b len=%0d required 1/64",
               s_good, s_len);
    end
  endtask

  task automatic test_rx_er();
    int q0, d0, got;
    q0 = rx_q.size();
    d0 = done_cnt;
    build_frame(60);
    send_frame(0, 1'b0, 20);
    got = rx_q.size() - q0;
    checks++;
    if (got !== 21) begin
      failures++;
      $display("FAIL rxer_count: got %0d required 21", got);
    end
    checks++;
    if (done_cnt - d0 !== 1 || s_rx !== 1'b1 || s_good !== 1'b0 ||
        s_len !== 16'd20) begin
      failures++;
      $display("FAIL rxer_status: done=%0d rx=%b good=%b len=%0d required 1/1/0/20",
               done_cnt - d0, s_rx, s_good, s_len);
    end
  endtask

  task automatic test_align_len();
    int d0;
    d0 = done_cnt;
    build_frame(60);
    send_frame(2, 1'b0, -1);
    checks++;
    if (done_cnt - d0 !== 1 || s_align !== 1'b1 || s_crc !== 1'b0 ||
        s_good !== 1'b0 || s_len !== 16'd64) begin
      failures++;
      $display("FAIL align_status: done=%0d align=%b crc=%b good=%b len=%0d required 1/1/0/0/64",
               done_cnt - d0, s_align, s_crc, s_good, s_len);
    end
    d0 = done_cnt;
    build_frame(36);
    send_frame(0, 1'b0, -1);
    checks++;
    if (done_cnt - d0 !== 1 || s_lenerr !== 1'b1 || s_crc !== 1'b0 ||
        s_good !== 1'b0 || s_len !== 16'd40) begin
      failures++;
      $display("FAIL short_status: done=%0d len_err=%b crc=%b good=%b len=%0d required 1/1/0/0/40",
               done_cnt - d0, s_lenerr, s_crc, s_good, s_len);
    end
  endtask

  task automatic test_hunt_limit();
    int q0, d0;
    q0 = rx_q.size();
    d0 = done_cnt;
    build_frame(60);
    repeat (20) drive_byte(8'h55);
    drive_byte(8'hD5);
    for (int i = 0; i < frm.size(); i++) drive_byte(frm[i]);
    carrier_off();
    checks++;
    if (rx_q.size() - q0 !== 0 || done_cnt - d0 !== 0) begin
      failures++;
      $display("FAIL hunt_limit: bytes=%0d done=%0d required 0/0",
               rx_q.size() - q0, done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int q0, d0;
    logic [7:0] b;
    build_frame(60);
    preamble();
    for (int i = 0; i < 30; i++) drive_byte(frm[i]);
    checks++;
    if (bus.frame_active !== 1'b1) begin
      failures++;
      $display("FAIL mid_active: active=%b required 1", bus.frame_active);
    end
    b = frm[30];
    drive_dibit(b[1:0], 1'b1, 1'b0);
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.received_byte, bus.byte_valid, bus.frame_active,
         bus.frame_done, bus.frame_good, bus.frame_len, bus.err_crc,
         bus.err_align, bus.err_rx, bus.err_len} !== 33'd0) begin
      failures++;
      $display("FAIL mid_reset_outputs: nonzero output during reset");
    end
    drive_dibit(b[3:2], 1'b1, 1'b0);
    drive_dibit(b[5:4], 1'b1, 1'b0);
    reset = 1'b0;
    q0 = rx_q.size();
    d0 = done_cnt;
    drive_dibit(b[7:6], 1'b1, 1'b0);
    for (int i = 31; i < frm.size(); i++) drive_byte(frm[i]);
    carrier_off();
    checks++;
    if (rx_q.size() - q0 !== 0 || done_cnt - d0 !== 0) begin
      failures++;
      $display("FAIL mid_drop: bytes=%0d done=%0d required 0/0",
               rx_q.size() - q0, done_cnt - d0);
    end
    q0 = rx_q.size();
    d0 = done_cnt;
    send_frame(0, 1'b0, -1);
    checks++;
    if (rx_q.size() - q0 !== 65 || done_cnt - d0 !== 1 ||
        s_good !== 1'b1 || s_len !== 16'd64) begin
      failures++;
      $display("FAIL after_reset: bytes=%0d done=%0d good=%b len=%0d required 65/1/1/64",
               rx_q.size() - q0, done_cnt - d0, s_good, s_len);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_crc_error();
    test_crs_toggle();
    test_rx_er();
    test_align_len();
    test_hunt_limit();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
